// File: rtl/bbox_overlay.sv
// Draws up to N_BOX rectangle outlines over a pixel stream; box set is double-buffered and swapped at frame start.
// Latency: in_* to out_* is exactly 2 cycles, one pixel per clock, never stalls.
// Backpressure: box_wr_ready drops only in the commit cycle (and during reset); the pixel path has none.
module bbox_overlay #(
    parameter int N_BOX        = 4,
    parameter int THICK        = 2,
    parameter int VSYNC_ACTIVE = 0,
    localparam int IDX_W       = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [9:0]       in_x,
    input  logic [9:0]       in_y,
    input  logic             in_vde,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic [7:0]       in_red,
    input  logic [7:0]       in_green,
    input  logic [7:0]       in_blue,
    input  logic             box_wr_valid,
    output logic             box_wr_ready,
    input  logic [IDX_W-1:0] box_wr_idx,
    input  logic             box_wr_en,
    input  logic [9:0]       box_x0,
    input  logic [9:0]       box_y0,
    input  logic [9:0]       box_x1,
    input  logic [9:0]       box_y1,
    input  logic [23:0]      box_color,
    output logic [9:0]       out_x,
    output logic [9:0]       out_y,
    output logic             out_vde,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic [7:0]       out_red,
    output logic [7:0]       out_green,
    output logic [7:0]       out_blue,
    output logic             frame_tick
);

    typedef struct packed {
        logic        en;
        logic [9:0]  x0;
        logic [9:0]  y0;
        logic [9:0]  x1;
        logic [9:0]  y1;
        logic [23:0] color;
    } box_t;

    localparam logic       VS_ACT  = (VSYNC_ACTIVE != 0);
    localparam logic [9:0] THICK_W = 10'(THICK);

    box_t shadow_bank [N_BOX];
    box_t active_bank [N_BOX];
    box_t wr_box;
    logic prev_vsync;
    logic frame_start;
    logic wr_fire;

    // frame_tick and box_wr_ready are combinational from prev_vsync, in_vsync and reset_n,
    // so the tick lands in the commit cycle itself and both are forced low while in reset.
    assign frame_start  = (in_vsync == VS_ACT) && (prev_vsync != VS_ACT);
    assign frame_tick   = reset_n && frame_start;
    assign box_wr_ready = reset_n && !frame_start;
    assign wr_fire      = box_wr_valid && box_wr_ready;

    always_comb begin
        wr_box       = '0;
        wr_box.en    = box_wr_en;
        wr_box.x0    = box_x0;
        wr_box.y0    = box_y0;
        wr_box.x1    = box_x1;
        wr_box.y1    = box_y1;
        wr_box.color = box_color;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_vsync <= !VS_ACT;
            for (int i = 0; i < N_BOX; i++) begin
                shadow_bank[i] <= '0;
                active_bank[i] <= '0;
            end
        end else begin
            prev_vsync <= in_vsync;
            if (frame_start) begin
                for (int i = 0; i < N_BOX; i++) begin
                    active_bank[i] <= shadow_bank[i];
                end
            end
            if (wr_fire && (int'(box_wr_idx) < N_BOX)) begin
                shadow_bank[box_wr_idx] <= wr_box;
            end
        end
    end

    // Edge distances are only formed once the pixel is known to be inside the box, so no wrap.
    logic [N_BOX-1:0] hit_vec;
    logic [23:0]      hit_color;

    always_comb begin
        hit_vec   = '0;
        hit_color = '0;
        for (int i = N_BOX - 1; i >= 0; i--) begin
            if (active_bank[i].en &&
                in_x >= active_bank[i].x0 && in_x <= active_bank[i].x1 &&
                in_y >= active_bank[i].y0 && in_y <= active_bank[i].y1 &&
                (((in_x - active_bank[i].x0) < THICK_W) ||
                 ((active_bank[i].x1 - in_x) < THICK_W) ||
                 ((in_y - active_bank[i].y0) < THICK_W) ||
                 ((active_bank[i].y1 - in_y) < THICK_W))) begin
                hit_vec[i] = 1'b1;
                hit_color  = active_bank[i].color;
            end
        end
    end

    logic [9:0]       s1_x;
    logic [9:0]       s1_y;
    logic             s1_vde;
    logic             s1_hsync;
    logic             s1_vsync;
    logic [23:0]      s1_rgb;
    logic [N_BOX-1:0] s1_hit;
    logic [23:0]      s1_color;
    logic [23:0]      pix_rgb;

    // Winning colour is captured with the hit vector so a commit between stages cannot mix banks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_x     <= '0;
            s1_y     <= '0;
            s1_vde   <= 1'b0;
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_rgb   <= '0;
            s1_hit   <= '0;
            s1_color <= '0;
        end else begin
            s1_x     <= in_x;
            s1_y     <= in_y;
            s1_vde   <= in_vde;
            s1_hsync <= in_hsync;
            s1_vsync <= in_vsync;
            s1_rgb   <= {in_red, in_green, in_blue};
            s1_hit   <= hit_vec;
            s1_color <= hit_color;
        end
    end

    always_comb begin
        pix_rgb = '0;
        if (s1_vde) begin
            pix_rgb = (|s1_hit) ? s1_color : s1_rgb;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_x     <= '0;
            out_y     <= '0;
            out_vde   <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
        end else begin
            out_x     <= s1_x;
            out_y     <= s1_y;
            out_vde   <= s1_vde;
            out_hsync <= s1_hsync;
            out_vsync <= s1_vsync;
            out_red   <= pix_rgb[23:16];
            out_green <= pix_rgb[15:8];
            out_blue  <= pix_rgb[7:0];
        end
    end

endmodule

// File: tb/tb_bbox_overlay.sv
// Directed bench for bbox_overlay: behavioural box model with a per-cycle compare plus hand-computed probes.
module tb_bbox_overlay;
    localparam int   N_BOX = 4;
    localparam int   THICK = 2;
    localparam logic VS    = 1'b0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  in_x, in_y;
    logic        in_vde, in_hsync, in_vsync;
    logic [7:0]  in_red, in_green, in_blue;
    logic        box_wr_valid, box_wr_ready;
    logic [1:0]  box_wr_idx;
    logic        box_wr_en;
    logic [9:0]  box_x0, box_y0, box_x1, box_y1;
    logic [23:0] box_color;
    logic [9:0]  out_x, out_y;
    logic        out_vde, out_hsync, out_vsync;
    logic [7:0]  out_red, out_green, out_blue;
    logic        frame_tick;

    always #5 clk = ~clk;

    bbox_overlay #(.N_BOX(N_BOX), .THICK(THICK), .VSYNC_ACTIVE(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_x(in_x), .in_y(in_y), .in_vde(in_vde), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .box_wr_valid(box_wr_valid), .box_wr_ready(box_wr_ready), .box_wr_idx(box_wr_idx),
        .box_wr_en(box_wr_en), .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1), .box_y1(box_y1),
        .box_color(box_color),
        .out_x(out_x), .out_y(out_y), .out_vde(out_vde), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue), .frame_tick(frame_tick)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          en;
        int          x0, y0, x1, y1;
        logic [23:0] col;
    } mbox_t;

    mbox_t       m_shadow [N_BOX];
    mbox_t       m_active [N_BOX];
    logic        m_prev = ~VS;
    logic        m_fs;
    logic        c_fs;
    logic [46:0] p1 = '0;
    logic [46:0] p2 = '0;

    function automatic logic [23:0] model_rgb(input int x, input int y, input logic vde,
                                              input logic [23:0] src);
        int d;
        if (!vde) return 24'h0;
        for (int i = 0; i < N_BOX; i++) begin
            if (m_active[i].en && x >= m_active[i].x0 && x <= m_active[i].x1 &&
                y >= m_active[i].y0 && y <= m_active[i].y1) begin
                d = x - m_active[i].x0;
                if (m_active[i].x1 - x < d) d = m_active[i].x1 - x;
                if (y - m_active[i].y0 < d) d = y - m_active[i].y0;
                if (m_active[i].y1 - y < d) d = m_active[i].y1 - y;
                if (d < THICK) return m_active[i].col;
            end
        end
        return src;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_prev = ~VS;
            p1 = '0;
            p2 = '0;
            for (int i = 0; i < N_BOX; i++) begin
                m_shadow[i] = '{0, 0, 0, 0, 0, 24'h0};
                m_active[i] = '{0, 0, 0, 0, 0, 24'h0};
            end
        end else begin
            m_fs = (in_vsync == VS) && (m_prev != VS);
            p2 = p1;
            p1 = {in_x, in_y, in_vde, in_hsync, in_vsync,
                  model_rgb(int'(in_x), int'(in_y), in_vde, {in_red, in_green, in_blue})};
            if (m_fs)
                for (int i = 0; i < N_BOX; i++) m_active[i] = m_shadow[i];
            if (box_wr_valid && !m_fs)
                m_shadow[box_wr_idx] = '{box_wr_en, int'(box_x0), int'(box_y0),
                                         int'(box_x1), int'(box_y1), box_color};
            m_prev = in_vsync;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("out_in_reset", 64'({out_x, out_y, out_vde, out_hsync, out_vsync,
                                        out_red, out_green, out_blue}), 64'h0);
            check("tick_in_reset", 64'(frame_tick), 64'h0);
            check("ready_in_reset", 64'(box_wr_ready), 64'h0);
        end else begin
            c_fs = (in_vsync == VS) && (m_prev != VS);
            check("out_bus", 64'({out_x, out_y, out_vde, out_hsync, out_vsync,
                                   out_red, out_green, out_blue}), 64'(p2));
            check("frame_tick", 64'(frame_tick), 64'(c_fs));
            check("wr_ready", 64'(box_wr_ready), 64'(!c_fs));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_pix(input int x, input int y, input logic vde, input logic hs, input logic vs);
        in_x     = 10'(x);
        in_y     = 10'(y);
        in_vde   = vde;
        in_hsync = hs;
        in_vsync = vs;
        in_red   = x[7:0];
        in_green = y[7:0];
        in_blue  = 8'h55;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic vde, input logic hs, input logic vs);
        set_pix(x, y, vde, hs, vs);
        cyc();
    endtask

    task automatic blank(input int n);
        for (int k = 0; k < n; k++) pix(700, 500, 1'b0, 1'b0, ~VS);
    endtask

    task automatic row(input int y, input int xs, input int xe);
        for (int x = xs; x <= xe; x++) pix(x, y, 1'b1, 1'b0, ~VS);
        for (int k = 0; k < 4; k++) pix(640 + k, y, 1'b0, 1'b1, ~VS);
    endtask

    task automatic set_box(input int idx, input logic en, input int x0, input int y0,
                           input int x1, input int y1, input logic [23:0] col);
        box_wr_idx = 2'(idx);
        box_wr_en  = en;
        box_x0     = 10'(x0);
        box_y0     = 10'(y0);
        box_x1     = 10'(x1);
        box_y1     = 10'(y1);
        box_color  = col;
    endtask

    task automatic write_box(input int idx, input logic en, input int x0, input int y0,
                             input int x1, input int y1, input logic [23:0] col);
        set_box(idx, en, x0, y0, x1, y1, col);
        box_wr_valid = 1'b1;
        blank(1);
        box_wr_valid = 1'b0;
    endtask

    // swap: change the held write data to box B in the commit cycle itself
    task automatic vsync_frame(input bit swap);
        set_pix(0, 490, 1'b0, 1'b0, VS);
        if (swap) set_box(1, 1'b1, 300, 200, 320, 220, 24'h654321);
        #1;
        check("tick_at_commit", 64'(frame_tick), 64'h1);
        check("ready_at_commit", 64'(box_wr_ready), 64'h0);
        cyc();
        set_pix(0, 491, 1'b0, 1'b0, VS);
        #1;
        check("tick_after_commit", 64'(frame_tick), 64'h0);
        check("ready_after_commit", 64'(box_wr_ready), 64'h1);
        cyc();
        box_wr_valid = 1'b0;
        pix(0, 492, 1'b0, 1'b0, VS);
        blank(2);
    endtask

    task automatic probe(input string name, input int x, input int y, input logic [23:0] exp);
        pix(x, y, 1'b1, 1'b0, ~VS);
        pix(700, y, 1'b0, 1'b0, ~VS);
        check(name, 64'({out_x, out_y, out_red, out_green, out_blue}),
              64'({10'(x), 10'(y), exp}));
    endtask

    initial begin
        reset_n      = 1'b0;
        box_wr_valid = 1'b0;
        set_box(0, 1'b0, 0, 0, 0, 0, 24'h0);
        set_pix(700, 500, 1'b0, 1'b0, ~VS);
        repeat (3) cyc();
        check("reset_rgb", 64'({out_red, out_green, out_blue, out_vde}), 64'h0);
        check("reset_ready", 64'(box_wr_ready), 64'h0);
        reset_n = 1'b1;
        blank(3);
        check("ready_after_release", 64'(box_wr_ready), 64'h1);

        // pass-through
        vsync_frame(0);
        row(0, 0, 639);
        row(240, 0, 200);
        row(479, 0, 639);
        probe("pass_37_21", 37, 21, 24'h251555);

        // single box; current frame must stay untouched
        write_box(0, 1'b1, 100, 50, 199, 149, 24'hFF0000);
        row(50, 95, 205);
        probe("pre_commit_100_50", 100, 50, 24'h643255);
        vsync_frame(0);
        row(50, 95, 205);
        row(51, 95, 205);
        row(100, 95, 205);
        row(149, 95, 205);
        row(150, 95, 105);
        probe("box_100_50", 100, 50, 24'hFF0000);
        probe("box_101_120", 101, 120, 24'hFF0000);
        probe("box_198_100", 198, 100, 24'hFF0000);
        probe("box_199_149", 199, 149, 24'hFF0000);
        probe("box_150_51", 150, 51, 24'hFF0000);
        probe("box_150_148", 150, 148, 24'hFF0000);
        probe("inner_102_52", 102, 52, 24'h663455);
        probe("inner_150_100", 150, 100, 24'h966455);
        probe("outside_200_100", 200, 100, 24'hC86455);

        // priority
        write_box(0, 1'b1, 10, 10, 50, 50, 24'h00FF00);
        write_box(2, 1'b1, 10, 10, 60, 60, 24'h0000FF);
        vsync_frame(0);
        row(10, 0, 70);
        row(30, 0, 70);
        probe("prio_10_10", 10, 10, 24'h00FF00);
        probe("prio_60_30", 60, 30, 24'h0000FF);
        probe("prio_11_30", 11, 30, 24'h00FF00);
        probe("prio_52_30", 52, 30, 24'h341E55);

        // commit handshake: valid held across the vsync edge
        set_box(1, 1'b1, 200, 200, 220, 220, 24'h123456);
        box_wr_valid = 1'b1;
        blank(2);
        vsync_frame(1);
        row(210, 195, 325);
        probe("hs_old_200_210", 200, 210, 24'h123456);
        probe("hs_new_hidden_300_210", 300, 210, 24'h2CD255);
        vsync_frame(0);
        row(210, 195, 325);
        probe("hs_old_gone_200_210", 200, 210, 24'hC8D255);
        probe("hs_new_300_210", 300, 210, 24'h654321);

        // degenerate boxes
        write_box(3, 1'b1, 300, 300, 200, 400, 24'hFFFFFF);
        write_box(0, 1'b1, 5, 5, 7, 7, 24'hABCDEF);
        write_box(2, 1'b1, 639, 479, 639, 479, 24'h0F0F0F);
        write_box(1, 1'b0, 300, 200, 320, 220, 24'h654321);
        vsync_frame(0);
        for (int y = 4; y <= 8; y++) row(y, 3, 9);
        row(300, 190, 310);
        row(479, 600, 639);
        probe("inv_250_350", 250, 350, 24'hFA5E55);
        probe("inv_200_300", 200, 300, 24'hC82C55);
        probe("inv_300_300", 300, 300, 24'h2C2C55);
        probe("solid_6_6", 6, 6, 24'hABCDEF);
        probe("solid_5_7", 5, 7, 24'hABCDEF);
        probe("solid_out_8_6", 8, 6, 24'h080655);
        probe("corner_639_479", 639, 479, 24'h0F0F0F);
        probe("corner_out_638_479", 638, 479, 24'h7EDF55);

        // reset mid-frame at row 200
        for (int x = 0; x < 50; x++) pix(x, 200, 1'b1, 1'b0, ~VS);
        reset_n = 1'b0;
        #1;
        check("midreset_out", 64'({out_vde, out_red, out_green, out_blue}), 64'h0);
        for (int x = 50; x < 53; x++) pix(x, 200, 1'b1, 1'b0, ~VS);
        reset_n = 1'b1;
        for (int x = 53; x <= 100; x++) pix(x, 200, 1'b1, 1'b0, ~VS);
        row(6, 0, 10);
        vsync_frame(0);
        row(6, 0, 10);
        row(479, 630, 639);
        probe("post_reset_6_6", 6, 6, 24'h060655);
        probe("post_reset_639_479", 639, 479, 24'h7FDF55);
        blank(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
